// File: rtl/enemy_hit_scheduler.sv
// enemy_hit_scheduler
//   Time-multiplexes one bullet/enemy collision comparator across NUM_EN enemy
//   slots (one slot per clock, round robin). Each slot runs an
//   ALIVE -> BOOM -> REVIVE life cycle with its own health and timer.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   ep_x, ep_y     packed enemy positions, slot i at [10i+9:10i]
//   enemy_en       per-slot enemy present
//   b_x, b_y       player bullet position
//   bullet_valid   player bullet exists
//   health_init    health loaded at reset and on revive (0 loads as 1)
//   bullet_consume one-cycle pulse: bullet hit something, retire it
//   hit_pulse      one-cycle pulse, same timing as bullet_consume
//   hit_idx        slot index of the last hit, held between hits
//   boom, revive   per-slot state decodes
module enemy_hit_scheduler #(
    parameter int unsigned NUM_EN     = 4,
    parameter int unsigned BOOM_CYC   = 32'h03FFFFFF,
    parameter int unsigned REVIVE_CYC = 375000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [10*NUM_EN-1:0] ep_x,
    input  logic [10*NUM_EN-1:0] ep_y,
    input  logic [NUM_EN-1:0]    enemy_en,
    input  logic [9:0]           b_x,
    input  logic [9:0]           b_y,
    input  logic                 bullet_valid,
    input  logic [2:0]           health_init,
    output logic                 bullet_consume,
    output logic                 hit_pulse,
    output logic [1:0]           hit_idx,
    output logic [NUM_EN-1:0]    boom,
    output logic [NUM_EN-1:0]    revive
);

    localparam int unsigned SW = (NUM_EN > 1) ? $clog2(NUM_EN) : 1;

    localparam logic [1:0] ST_ALIVE  = 2'd0;
    localparam logic [1:0] ST_BOOM   = 2'd1;
    localparam logic [1:0] ST_REVIVE = 2'd2;

    logic [SW-1:0]     scan_idx_q, scan_idx_d;
    logic              armed_q, armed_d;
    logic              prev_valid_q, prev_valid_d;
    logic              consume_q, consume_d;
    logic [1:0]        hit_idx_q, hit_idx_d;
    logic [1:0]        state_q  [NUM_EN];
    logic [1:0]        state_d  [NUM_EN];
    logic [2:0]        health_q [NUM_EN];
    logic [2:0]        health_d [NUM_EN];
    logic [31:0]       cnt_q    [NUM_EN];
    logic [31:0]       cnt_d    [NUM_EN];

    logic [NUM_EN-1:0] win;
    logic [NUM_EN-1:0] hit_vec;
    logic              hit_any;
    logic [2:0]        health_load;

    assign health_load = (health_init == 3'd0) ? 3'd1 : health_init;

    // Window is evaluated for every slot in 11 bits so +offsets never wrap;
    // only the slot under the scan pointer may turn it into a hit.
    always_comb begin
        win     = '0;
        hit_vec = '0;
        for (int unsigned i = 0; i < NUM_EN; i++) begin
            win[i] = (({1'b0, b_x} + 11'd10) >= {1'b0, ep_x[10*i +: 10]}) &&
                     ({1'b0, b_x} < ({1'b0, ep_x[10*i +: 10]} + 11'd50)) &&
                     (({1'b0, b_y} + 11'd40) > {1'b0, ep_y[10*i +: 10]}) &&
                     ({1'b0, b_y} < ({1'b0, ep_y[10*i +: 10]} + 11'd50));
            hit_vec[i] = win[i] && armed_q && enemy_en[i] &&
                         (scan_idx_q == SW'(i)) &&
                         (state_q[i] == ST_ALIVE) &&
                         (health_q[i] != 3'd0);
        end
        hit_any = |hit_vec;
    end

    always_comb begin
        scan_idx_d = (scan_idx_q == SW'(NUM_EN - 1)) ? '0 : scan_idx_q + SW'(1);
        consume_d  = hit_any;
        hit_idx_d  = hit_any ? 2'(scan_idx_q) : hit_idx_q;

        // Arming needs a low sample followed by a high one; a hit disarms
        // immediately, which also shields the next scanned slot.
        prev_valid_d = bullet_valid;
        if (hit_any || !bullet_valid) begin
            armed_d = 1'b0;
        end else if (!prev_valid_q) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end

        for (int unsigned i = 0; i < NUM_EN; i++) begin
            state_d[i]  = state_q[i];
            health_d[i] = health_q[i];
            cnt_d[i]    = cnt_q[i];
            case (state_q[i])
                ST_ALIVE: begin
                    if (hit_vec[i]) begin
                        health_d[i] = health_q[i] - 3'd1;
                        if (health_q[i] == 3'd1) begin
                            state_d[i] = ST_BOOM;
                            cnt_d[i]   = '0;
                        end
                    end
                end
                ST_BOOM: begin
                    if (cnt_q[i] == BOOM_CYC - 1) begin
                        state_d[i]  = ST_REVIVE;
                        health_d[i] = health_load;
                        cnt_d[i]    = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 32'd1;
                    end
                end
                ST_REVIVE: begin
                    if (cnt_q[i] == REVIVE_CYC - 1) begin
                        state_d[i] = ST_ALIVE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 32'd1;
                    end
                end
                default: begin
                    state_d[i] = ST_ALIVE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_idx_q   <= '0;
            armed_q      <= 1'b0;
            // Treat the bullet as already seen high so a bullet held through
            // reset cannot arm until it drops.
            prev_valid_q <= 1'b1;
            consume_q    <= 1'b0;
            hit_idx_q    <= '0;
            for (int unsigned i = 0; i < NUM_EN; i++) begin
                state_q[i]  <= ST_ALIVE;
                health_q[i] <= health_load;
                cnt_q[i]    <= '0;
            end
        end else begin
            scan_idx_q   <= scan_idx_d;
            armed_q      <= armed_d;
            prev_valid_q <= prev_valid_d;
            consume_q    <= consume_d;
            hit_idx_q    <= hit_idx_d;
            for (int unsigned i = 0; i < NUM_EN; i++) begin
                state_q[i]  <= state_d[i];
                health_q[i] <= health_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    always_comb begin
        boom   = '0;
        revive = '0;
        for (int unsigned i = 0; i < NUM_EN; i++) begin
            boom[i]   = (state_q[i] == ST_BOOM);
            revive[i] = (state_q[i] == ST_REVIVE);
        end
    end

    assign bullet_consume = consume_q;
    assign hit_pulse      = consume_q;
    assign hit_idx        = hit_idx_q;

endmodule

// File: doc/enemy_hit_scheduler.md
ENEMY_HIT_SCHEDULER -- requirements
Module: enemy_hit_scheduler

Interface
REQ-001 Parameter: NUM_EN, default 4, number of enemy slots sharing one collision comparator.
REQ-002 Parameter: BOOM_CYC, default 32'h03FFFFFF, clock cycles a slot stays in BOOM.
REQ-003 Parameter: REVIVE_CYC, default 375000, clock cycles a slot stays in REVIVE.
REQ-004 Port: clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port: ep_x, ep_y  input  10*NUM_EN each  packed enemy positions; slot i at bits [10i+9:10i].
REQ-007 Port: enemy_en  input  NUM_EN  1 = slot i enemy present.
REQ-008 Port: b_x, b_y  input  10 each  player bullet position, same coordinate space as enemies.
REQ-009 Port: bullet_valid  input  1  1 = player bullet exists.
REQ-010 Port: health_init  input  3  health loaded at reset and on revive.
REQ-011 Port: bullet_consume  output  1  one-cycle pulse: bullet hit something, shooter must retire it.
REQ-012 Port: hit_pulse  output  1  one-cycle pulse coincident with bullet_consume.
REQ-013 Port: hit_idx  output  2  slot index of last hit; holds between hits.
REQ-014 Port: boom, revive  output  NUM_EN each  1 = slot i in BOOM / REVIVE state.

Function
REQ-015 Scan pointer scan_idx SHALL step 0,1,..,NUM_EN-1,0 every cycle, one slot evaluated per cycle.
REQ-016 Per-slot FSM SHALL have states ALIVE, BOOM, REVIVE; boom[i]/revive[i] are decodes of state.
REQ-017 Hit window SHALL be computed in 11-bit unsigned, no wrap: b_x+10 >= ep_x, b_x < ep_x+50, b_y+40 > ep_y, b_y < ep_y+50.
REQ-018 Slot scan_idx is hittable only if state ALIVE, enemy_en set, health nonzero, bullet armed, and window true.
REQ-019 On hit: next cycle bullet_consume=1, hit_pulse=1, hit_idx=slot, slot health decremented by 1, bullet disarmed.
REQ-020 Bullet armed flag SHALL set only after bullet_valid has been sampled low then high; one bullet produces at most one hit.
REQ-021 A hit cycle's disarm SHALL block the following scanned slot even if also overlapping (no double-hit).
REQ-022 Health reaching 0 via hit SHALL move slot to BOOM on the same edge as the decrement; its counter clears.
REQ-023 BOOM: counter increments each cycle; at count == BOOM_CYC-1 slot SHALL go REVIVE, health reloaded, counter cleared.
REQ-024 REVIVE: at count == REVIVE_CYC-1 slot SHALL go ALIVE, counter cleared.
REQ-025 Health load value SHALL be health_init, or 1 if health_init is 0.
REQ-026 Slot timers SHALL run regardless of enemy_en and scan_idx; only hit evaluation is gated.
REQ-027 enemy_en low in ALIVE SHALL keep health unchanged; slot merely unhittable.
REQ-028 Non-hit cycles: bullet_consume=0, hit_pulse=0.

Reset
REQ-029 rst_n low at a clock edge SHALL set scan_idx=0, all slots ALIVE, counters 0, health = load value, armed=0, bullet_consume=0, hit_pulse=0, hit_idx=0, boom=0, revive=0.
REQ-030 Reset mid-BOOM/REVIVE SHALL abort timers; bullet_valid held high through reset SHALL NOT arm until seen low.

Verification (BOOM_CYC=8, REVIVE_CYC=4, NUM_EN=4)
REQ-031 Slot 2 at (100,100), health_init=2, bullet 0->1 at (120,120) -> one consume pulse, hit_idx=2, health 1, no further hits while bullet_valid held.
REQ-032 Second fresh bullet on slot 2 -> health 0, boom[2]=1 for exactly 8 cycles, then revive[2]=1 for 4 cycles, then ALIVE with health 2.
REQ-033 Window edges on slot 0 at (100,100): b_x=90 hits, b_x=89 misses, b_x=149 hits, b_x=150 misses; ep_x=5 with b_x=0 hits (no wrap).
REQ-034 Slots 1 and 2 both overlapping bullet -> exactly one consume, hit_idx=1.
REQ-035 enemy_en[3]=0 with overlap -> no hit; health_init=0 -> slots load health 1, single hit booms.
REQ-036 rst_n low 3 cycles during BOOM with bullet_valid high -> all outputs reset values, no hit until bullet_valid toggles low/high.
